// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM-WB stage.
// Misses stall the core via `miss` while the victim is written back and the line refilled.
module data_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3,
    parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [3:0]  wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int SET_SIZE  = 1 << SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t state, state_next;

    logic [31:0]              line_data [SET_SIZE][LINE_SIZE];
    logic [TAG_ADDR_LEN-1:0]  tag_arr   [SET_SIZE];
    logic [SET_SIZE-1:0]      valid;
    logic [SET_SIZE-1:0]      dirty;

    logic [LINE_ADDR_LEN-1:0] word_cnt;
    logic [SET_ADDR_LEN-1:0]  miss_set;
    logic [TAG_ADDR_LEN-1:0]  miss_tag;
    logic                     replay;

    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag_in;
    logic                     req;
    logic                     store;
    logic                     hit;
    logic                     last_word;
    logic                     unused_ok;

    assign word_idx  = addr[LINE_ADDR_LEN+1:2];
    assign set_idx   = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign tag_in    = addr[31:32-TAG_ADDR_LEN];
    // Byte offset plays no part in word-granular lookups.
    assign unused_ok = &{1'b0, addr[1:0]};

    assign store     = |wr_req;
    assign req       = rd_req | store;
    assign hit       = valid[set_idx] && (tag_arr[set_idx] == tag_in);
    assign last_word = (word_cnt == '1);
    assign rd_data   = line_data[set_idx][word_idx];

    always_comb begin
        state_next = state;
        miss       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    miss       = 1'b1;
                    state_next = (valid[set_idx] && dirty[set_idx]) ? WB : FILL;
                end
            end
            WB: begin
                miss      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_arr[miss_set], miss_set, word_cnt, 2'b00};
                mem_wdata = line_data[miss_set][word_cnt];
                if (mem_ack && last_word) state_next = FILL;
            end
            FILL: begin
                miss     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_set, word_cnt, 2'b00};
                if (mem_ack && last_word) state_next = DONE;
            end
            DONE: begin
                miss       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            dirty    <= '0;
            word_cnt <= '0;
            miss_set <= '0;
            miss_tag <= '0;
            replay   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    replay <= 1'b0;
                    if (req && hit) begin
                        // The hit that replays a just-finished miss is not a fresh hit.
                        if (!replay) hit_cnt <= hit_cnt + 32'd1;
                        if (store) dirty[set_idx] <= 1'b1;
                    end else if (req) begin
                        miss_cnt <= miss_cnt + 32'd1;
                        miss_set <= set_idx;
                        miss_tag <= tag_in;
                    end
                end
                WB, FILL: begin
                    if (mem_ack) word_cnt <= word_cnt + LINE_ADDR_LEN'(1);
                end
                DONE: begin
                    valid[miss_set] <= 1'b1;
                    dirty[miss_set] <= 1'b0;
                    replay          <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == IDLE && req && hit && store) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (wr_req[i]) line_data[set_idx][word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
            if (state == FILL && mem_ack) line_data[miss_set][word_cnt] <= mem_rdata;
            if (state == DONE) tag_arr[miss_set] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed miss/writeback/refill scenarios followed by random
// loads/stores checked against a word-level memory model and a per-set residency model.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [3:0]  wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    data_cache dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .miss(miss), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       xlog[$];
    logic [31:0] mem_store [int unsigned];
    logic [31:0] arch [int unsigned];

    int total = 0;
    int bad = 0;
    int ack_delay = 1;
    int unstable = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 32'hA5A50000;
    endfunction

    // Architectural value of a word: what any load must observe.
    function automatic logic [31:0] arch_read(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return a ^ 32'hA5A50000;
    endfunction

    function automatic void arch_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] v;
        v = arch_read(a);
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        arch[a] = v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Main memory: acks after ack_delay cycles per word (random 1..3 when ack_delay is 0).
    initial begin
        int          wait_cnt;
        int          target;
        logic [31:0] held_addr;
        logic [31:0] held_wdata;
        logic        held_we;
        wait_cnt   = 0;
        target     = 1;
        held_addr  = '0;
        held_wdata = '0;
        held_we    = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (wait_cnt == 0) begin
                    target     = (ack_delay == 0) ? int'($urandom_range(3, 1)) : ack_delay;
                    held_addr  = mem_addr;
                    held_we    = mem_we;
                    held_wdata = mem_wdata;
                end else if (mem_addr !== held_addr || mem_we !== held_we ||
                             (mem_we && mem_wdata !== held_wdata)) begin
                    unstable++;
                end
                if (wait_cnt + 1 >= target) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_we ? 32'h0 : mem_read(mem_addr);
                    if (mem_we) mem_store[mem_addr] = mem_wdata;
                    xlog.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
                    wait_cnt  = 0;
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // One request held until the cache completes it; mc counts cycles with miss=1.
    task automatic access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, output int mc, output logic [31:0] data);
        xlog.delete();
        rd_req  = rd;
        wr_req  = be;
        addr    = a;
        wr_data = wd;
        mc      = 0;
        @(negedge clk);
        while (miss === 1'b1 && mc < 2000) begin
            mc++;
            @(negedge clk);
        end
        if (mc >= 2000) check("access_timeout", 32'(mc), 32'd0);
        data = rd_data;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_req = '0;
    endtask

    task automatic check_burst(input string tag, input int first, input logic we, input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            if (first + i < xlog.size()) begin
                check($sformatf("%s_we%0d", tag, i), 32'(xlog[first+i].we), 32'(we));
                check($sformatf("%s_addr%0d", tag, i), xlog[first+i].a, base + 32'(4 * i));
                if (we) check($sformatf("%s_data%0d", tag, i), xlog[first+i].d, arch_read(base + 32'(4 * i)));
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int          mc;
    logic [31:0] data;
    int          held_tag [8];
    bit          held_dirty [8];
    int          exp_hits;
    int          exp_misses;

    initial begin
        rst     = 1'b1;
        rd_req  = 1'b0;
        wr_req  = '0;
        addr    = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        #1;

        // Cold read: fill only.
        access(1'b1, 4'b0000, 32'h100, 32'h0, mc, data);
        check("s1_miss_cycles", 32'(mc), 32'd10);
        check("s1_xfers", 32'(xlog.size()), 32'd8);
        check_burst("s1_fill", 0, 1'b0, 32'h100);
        check("s1_rd_data", data, 32'hA5A50100);
        check("s1_miss_cnt", miss_cnt, 32'd1);
        check("s1_hit_cnt", hit_cnt, 32'd0);

        // Store hit with partial byte enables, then readback.
        access(1'b0, 4'b0011, 32'h104, 32'hAABBCCDD, mc, data);
        arch_store(32'h104, 4'b0011, 32'hAABBCCDD);
        check("s2_wr_miss_cycles", 32'(mc), 32'd0);
        check("s2_wr_xfers", 32'(xlog.size()), 32'd0);
        check("s2_wr_hit_cnt", hit_cnt, 32'd1);
        access(1'b1, 4'b0000, 32'h104, 32'h0, mc, data);
        check("s2_rd_miss_cycles", 32'(mc), 32'd0);
        check("s2_rd_data", data, 32'hA5A5CCDD);
        check("s2_hit_cnt", hit_cnt, 32'd2);

        // Conflict miss on a dirty line: writeback then fill.
        access(1'b1, 4'b0000, 32'h500, 32'h0, mc, data);
        check("s3_xfers", 32'(xlog.size()), 32'd16);
        check_burst("s3_wb", 0, 1'b1, 32'h100);
        if (xlog.size() > 1) check("s3_wb_word1", xlog[1].d, 32'hA5A5CCDD);
        check_burst("s3_fill", 8, 1'b0, 32'h500);
        check("s3_rd_data", data, 32'hA5A50500);
        check("s3_miss_cnt", miss_cnt, 32'd2);

        // Conflict miss on a clean line: no writeback.
        access(1'b1, 4'b0000, 32'h900, 32'h0, mc, data);
        check("s4_xfers", 32'(xlog.size()), 32'd8);
        check_burst("s4_fill", 0, 1'b0, 32'h900);
        check("s4_rd_data", data, 32'hA5A50900);
        check("s4_miss_cnt", miss_cnt, 32'd3);

        // Slow memory: three cycles per word.
        ack_delay = 3;
        unstable  = 0;
        access(1'b1, 4'b0000, 32'h100, 32'h0, mc, data);
        check("s5_miss_cycles", 32'(mc), 32'd26);
        check("s5_unstable", 32'(unstable), 32'd0);
        check("s5_xfers", 32'(xlog.size()), 32'd8);
        check_burst("s5_fill", 0, 1'b0, 32'h100);
        check("s5_rd_data", data, 32'hA5A50100);
        check("s5_miss_cnt", miss_cnt, 32'd4);
        check("s5_hit_cnt", hit_cnt, 32'd2);
        ack_delay = 1;

        // Reset in the middle of a fill.
        xlog.delete();
        rd_req = 1'b1;
        addr   = 32'h200;
        begin
            int n;
            n = 0;
            while (xlog.size() < 3 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 200) check("s6_fill_timeout", 32'(n), 32'd0);
        end
        rst    = 1'b1;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("s6_mem_req", 32'(mem_req), 32'd0);
        check("s6_mem_addr", mem_addr, 32'd0);
        check("s6_hit_cnt", hit_cnt, 32'd0);
        check("s6_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        #1;
        access(1'b1, 4'b0000, 32'h500, 32'h0, mc, data);
        check("s6_miss_cycles", 32'(mc), 32'd10);
        check("s6_xfers", 32'(xlog.size()), 32'd8);
        check_burst("s6_fill", 0, 1'b0, 32'h500);
        check("s6_rd_data", data, 32'hA5A50500);
        check("s6_miss_cnt", miss_cnt, 32'd1);

        // Random traffic from a fresh reset; memory latency random per word.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            held_tag[s]   = -1;
            held_dirty[s] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        ack_delay  = 0;
        unstable   = 0;
        for (int k = 0; k < 150; k++) begin
            int          t;
            int          s;
            int          w;
            int          op;
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  be;
            logic        rd;
            bit          pmiss;
            bit          pwb;
            logic [31:0] pre;
            t  = int'($urandom_range(3, 0));
            s  = int'($urandom_range(7, 0));
            w  = int'($urandom_range(7, 0));
            op = int'($urandom_range(2, 0));
            a  = (32'(t) << 8) | (32'(s) << 5) | (32'(w) << 2);
            wd = $urandom;
            rd = (op != 1);
            be = (op == 0) ? 4'b0000 : 4'($urandom_range(15, 1));
            pmiss = (held_tag[s] != t);
            pwb   = pmiss && held_dirty[s];
            pre   = arch_read(a);
            access(rd, be, a, wd, mc, data);
            check($sformatf("rnd%0d_miss", k), 32'(mc != 0), 32'(pmiss));
            check($sformatf("rnd%0d_xfers", k), 32'(xlog.size()), pmiss ? (pwb ? 32'd16 : 32'd8) : 32'd0);
            if (pwb) check_burst($sformatf("rnd%0d_wb", k), 0, 1'b1, (32'(held_tag[s]) << 8) | (32'(s) << 5));
            if (pmiss) check_burst($sformatf("rnd%0d_fill", k), pwb ? 8 : 0, 1'b0, (32'(t) << 8) | (32'(s) << 5));
            if (rd) check($sformatf("rnd%0d_rd_data", k), data, pre);
            if (pmiss) begin
                held_tag[s]   = t;
                held_dirty[s] = 1'b0;
                exp_misses++;
            end else begin
                exp_hits++;
            end
            if (be != 4'b0000) begin
                arch_store(a, be, wd);
                held_dirty[s] = 1'b1;
            end
        end
        check("rnd_hit_cnt", hit_cnt, 32'(exp_hits));
        check("rnd_miss_cnt", miss_cnt, 32'(exp_misses));
        check("rnd_unstable", 32'(unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
